// File: rtl/lcd_controller.sv
// HD44780-style LCD write controller driven as a custom instruction; one op per start, done pulses after the final byte wait.
// 8-bit CMD/DATA latency T_SU+T_EN+1+T_WAIT+1 cycles; start is ignored while busy and clk_en low freezes everything.
module lcd_controller #(
   parameter int CLK_HZ        = 50_000_000,
   parameter int BUS_MODE      = 8,
   parameter int INIT_ON_RESET = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_en,
   input  logic        start,
   input  logic [31:0] dataa,
   input  logic [31:0] datab,
   output logic [31:0] result,
   output logic        done,
   output logic        lcd_enable,
   output logic        lcd_rs,
   output logic        lcd_rw,
   output logic [7:0]  lcd_data
);

   localparam int T_SU   = CLK_HZ / 10_000_000 + 1;
   localparam int T_EN   = CLK_HZ / 2_000_000 + 1;
   localparam int T_CMD  = CLK_HZ / 25_000;
   localparam int T_LONG = CLK_HZ / 610;
   localparam int T_PWR  = 15 * (CLK_HZ / 1000);
   localparam int T_MAX1 = (T_PWR > T_LONG) ? T_PWR : T_LONG;
   localparam int T_MAX2 = (T_MAX1 > T_CMD) ? T_MAX1 : T_CMD;
   localparam int T_MAX  = (T_MAX2 > T_EN) ? T_MAX2 : T_EN;
   localparam int CW     = $clog2(T_MAX + 1);

   localparam logic [CW-1:0] SU_END   = CW'(T_SU - 1);
   localparam logic [CW-1:0] EN_END   = CW'(T_EN - 1);
   localparam logic [CW-1:0] CMD_END  = CW'(T_CMD);
   localparam logic [CW-1:0] LONG_END = CW'(T_LONG);
   localparam logic [CW-1:0] PWR_END  = CW'(T_PWR - 1);
   localparam logic [2:0]    INIT_LAST = (BUS_MODE == 4) ? 3'd4 : 3'd3;

   typedef enum logic [2:0] {PWR_WAIT, IDLE, SETUP, PULSE, HOLD, WAIT} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic [CW-1:0] wait_end;
   logic [7:0]    byte_q, byte_nx;
   logic          rs_q, rs_nx;
   logic          nib_lo, nib_lo_nx;
   logic          nib_only, nib_only_nx;
   logic          init_run, init_run_nx;
   logic          auto_q, auto_nx;
   logic [2:0]    seq_idx, seq_nx;
   logic          fin;
   logic          gap;
   logic [8:0]    item;
   logic          unused_bits;

   // {high-nibble-only flag, byte} for each step of the init sequence
   function automatic logic [8:0] init_item(input logic [2:0] idx);
      logic [8:0] it;
      it = 9'h001;
      if (BUS_MODE == 4) begin
         case (idx)
            3'd0:    it = {1'b1, 8'h20};
            3'd1:    it = 9'h028;
            3'd2:    it = 9'h00C;
            3'd3:    it = 9'h006;
            default: it = 9'h001;
         endcase
      end else begin
         case (idx)
            3'd0:    it = 9'h038;
            3'd1:    it = 9'h00C;
            3'd2:    it = 9'h006;
            default: it = 9'h001;
         endcase
      end
      return it;
   endfunction

   // After a 4-bit high nibble only a short gap precedes the low nibble
   always_comb begin
      gap = (BUS_MODE == 4) && !nib_lo && !nib_only;
      if (gap)
         wait_end = EN_END;
      else if (!rs_q && !nib_only && (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03))
         wait_end = LONG_END;
      else
         wait_end = CMD_END;
   end

   always_comb begin
      state_nx    = state;
      byte_nx     = byte_q;
      rs_nx       = rs_q;
      nib_lo_nx   = nib_lo;
      nib_only_nx = nib_only;
      init_run_nx = init_run;
      auto_nx     = auto_q;
      seq_nx      = seq_idx;
      fin         = 1'b0;
      item        = '0;
      case (state)
         PWR_WAIT: begin
            if (cnt == PWR_END) begin
               item        = init_item(3'd0);
               byte_nx     = item[7:0];
               nib_only_nx = item[8];
               rs_nx       = 1'b0;
               nib_lo_nx   = 1'b0;
               seq_nx      = 3'd0;
               init_run_nx = 1'b1;
               auto_nx     = 1'b1;
               state_nx    = SETUP;
            end
         end
         IDLE: begin
            if (start) begin
               nib_lo_nx   = 1'b0;
               nib_only_nx = 1'b0;
               init_run_nx = 1'b0;
               auto_nx     = 1'b0;
               seq_nx      = 3'd0;
               rs_nx       = 1'b0;
               state_nx    = SETUP;
               case (dataa[1:0])
                  2'd0: begin
                     item        = init_item(3'd0);
                     byte_nx     = item[7:0];
                     nib_only_nx = item[8];
                     init_run_nx = 1'b1;
                  end
                  2'd1: byte_nx = datab[7:0];
                  2'd2: begin
                     byte_nx = datab[7:0];
                     rs_nx   = 1'b1;
                  end
                  default: byte_nx = {1'b1, datab[8], 2'b00, datab[3:0]};
               endcase
            end
         end
         SETUP: if (cnt == SU_END) state_nx = PULSE;
         PULSE: if (cnt == EN_END) state_nx = HOLD;
         HOLD:  state_nx = WAIT;
         WAIT: begin
            if (cnt == wait_end) begin
               if (gap) begin
                  nib_lo_nx = 1'b1;
                  state_nx  = SETUP;
               end else if (init_run && seq_idx != INIT_LAST) begin
                  seq_nx      = seq_idx + 3'd1;
                  item        = init_item(seq_idx + 3'd1);
                  byte_nx     = item[7:0];
                  nib_only_nx = item[8];
                  nib_lo_nx   = 1'b0;
                  rs_nx       = 1'b0;
                  state_nx    = SETUP;
               end else begin
                  init_run_nx = 1'b0;
                  fin         = !auto_q;
                  state_nx    = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= (INIT_ON_RESET != 0) ? PWR_WAIT : IDLE;
         cnt        <= '0;
         byte_q     <= '0;
         rs_q       <= 1'b0;
         nib_lo     <= 1'b0;
         nib_only   <= 1'b0;
         init_run   <= 1'b0;
         auto_q     <= 1'b0;
         seq_idx    <= '0;
         lcd_enable <= 1'b0;
         done       <= 1'b0;
         result     <= '0;
      end else if (clk_en) begin
         state      <= state_nx;
         cnt        <= (state_nx != state || state == IDLE) ? '0 : cnt + 1'b1;
         byte_q     <= byte_nx;
         rs_q       <= rs_nx;
         nib_lo     <= nib_lo_nx;
         nib_only   <= nib_only_nx;
         init_run   <= init_run_nx;
         auto_q     <= auto_nx;
         seq_idx    <= seq_nx;
         lcd_enable <= (state_nx == PULSE);
         done       <= fin;
         if (fin)
            result <= {24'h0, byte_q};
      end
   end

   assign lcd_data    = (BUS_MODE == 4) ? {(nib_lo ? byte_q[3:0] : byte_q[7:4]), 4'h0} : byte_q;
   assign lcd_rs      = rs_q;
   assign lcd_rw      = 1'b0;
   assign unused_bits = ^{dataa[31:2], datab[31:9]};

endmodule
